// File: rtl/piano_pkg.sv
// Shared piano-system constants and event layout.
// Reused by the key front end and the audio/VGA stages.
package piano_pkg;

  localparam int NUM_KEYS        = 16;
  localparam int KEY_IDX_W       = 4;
  localparam int TICK_DIV_100MHZ = 100000;

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    logic                 press;
  } key_evt_t;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: synchronizer, stability counter and
// stable/pending/dir state.
module key_debounce_cell #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  input  logic clr,
  output logic stable,
  output logic pending,
  output logic dir,
  output logic overrun
);

  localparam int CW = $clog2(STABLE_CNT);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;
  logic                   flip;

  assign sync = sync_q[SYNC_STAGES-1];
  assign flip = tick && (sync != stable) && (cnt == CMAX);

  // A flip coinciding with the load of this key is not lost.
  assign overrun = flip && pending && !clr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt     <= '0;
      stable  <= 1'b0;
      pending <= 1'b0;
      dir     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (tick) begin
        if (sync == stable) begin
          cnt <= '0;
        end else if (cnt == CMAX) begin
          cnt    <= '0;
          stable <= ~stable;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (flip) begin
        pending <= 1'b1;
        dir     <= ~stable;
      end else if (clr) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_scan_debouncer.sv
// Key matrix front end: debounced key vector plus
// a press/release event stream with valid/ready.
module key_scan_debouncer #(
  parameter int NUM_KEYS    = piano_pkg::NUM_KEYS,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = piano_pkg::TICK_DIV_100MHZ,
  parameter int STABLE_CNT  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         keys_raw,
  output logic [NUM_KEYS-1:0]         keys_stable,
  output logic                        any_key,
  output logic [$clog2(NUM_KEYS)-1:0] active_key,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic                        evt_press,
  output logic                        evt_overrun
);

  import piano_pkg::*;

  localparam int IW = $clog2(NUM_KEYS);
  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]       tcnt;
  logic                tick;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] dir;
  logic [NUM_KEYS-1:0] ovr;
  logic [NUM_KEYS-1:0] clr;
  logic                hit;
  logic                free;
  logic [IW-1:0]       sel;
  logic [IW-1:0]       act;
  key_evt_t            evt_q;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_CNT  (STABLE_CNT)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .raw     (keys_raw[i]),
      .tick    (tick),
      .clr     (clr[i]),
      .stable  (stable[i]),
      .pending (pending[i]),
      .dir     (dir[i]),
      .overrun (ovr[i])
    );
  end

  // Descending scan leaves the lowest set index in sel/act.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    act = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        hit = 1'b1;
        sel = IW'(i);
      end
      if (stable[i]) act = IW'(i);
    end
    free = !evt_valid || evt_ready;
    clr  = (free && hit) ? (NUM_KEYS'(1) << sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt        <= '0;
      evt_valid   <= 1'b0;
      evt_q       <= '0;
      evt_overrun <= 1'b0;
      any_key     <= 1'b0;
      active_key  <= '0;
    end else begin
      tcnt <= tick ? '0 : tcnt + TW'(1);
      if (free) begin
        evt_valid <= hit;
        if (hit) begin
          evt_q.key   <= sel;
          evt_q.press <= dir[sel];
        end
      end
      evt_overrun <= |ovr;
      any_key     <= |stable;
      active_key  <= act;
    end
  end

  assign keys_stable = stable;
  assign evt_key     = evt_q.key;
  assign evt_press   = evt_q.press;

endmodule

// File: tb/tb_key_scan_debouncer.sv
// Directed and random checks of the key front end
// against a per-edge behavioural model.
module tb_key_scan_debouncer;

  localparam int TD = 4;
  localparam int SC = 3;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] keys_raw;
  logic [15:0] keys_stable;
  logic        any_key;
  logic [3:0]  active_key;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_key;
  logic        evt_press;
  logic        evt_overrun;

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  logic [4:0] evq[$];

  // model state: raw history, run lengths, event slot
  logic [15:0] h1, h2;
  logic [15:0] m_stb, m_pend, m_dir;
  int          m_run[16];
  int          m_phase;
  logic        m_v, m_p, m_ovr, m_any;
  logic [3:0]  m_k, m_act;

  key_scan_debouncer #(
    .NUM_KEYS    (16),
    .SYNC_STAGES (SS),
    .TICK_DIV    (TD),
    .STABLE_CNT  (SC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys_raw    (keys_raw),
    .keys_stable (keys_stable),
    .any_key     (any_key),
    .active_key  (active_key),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_press   (evt_press),
    .evt_overrun (evt_overrun)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input logic [15:0] v);
    lowest = -1;
    for (int i = 15; i >= 0; i--) if (v[i]) lowest = i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic [15:0] flip;
    logic [15:0] served;
    int lp;
    int la;
    if (!reset) begin
      h1 = '0; h2 = '0; m_stb = '0; m_pend = '0; m_dir = '0;
      foreach (m_run[i]) m_run[i] = 0;
      m_phase = 0; m_v = 0; m_p = 0; m_k = '0;
      m_ovr = 0; m_any = 0; m_act = '0;
    end else begin
      flip = '0;
      served = '0;
      if (m_phase == TD - 1) begin
        for (int i = 0; i < 16; i++) begin
          if (h2[i] == m_stb[i]) m_run[i] = 0;
          else if (m_run[i] + 1 == SC) begin
            flip[i] = 1'b1;
            m_run[i] = 0;
          end else m_run[i] = m_run[i] + 1;
        end
      end
      m_phase = (m_phase + 1) % TD;
      if (!m_v || evt_ready) begin
        lp = lowest(m_pend);
        m_v = (lp >= 0);
        if (lp >= 0) begin
          m_k = 4'(lp);
          m_p = m_dir[lp];
          served[lp] = 1'b1;
        end
      end
      m_ovr = |(flip & m_pend & ~served);
      m_any = |m_stb;
      la = lowest(m_stb);
      m_act = (la < 0) ? 4'd0 : 4'(la);
      m_pend = (m_pend & ~served) | flip;
      m_dir = (m_dir & ~flip) | (~m_stb & flip);
      m_stb = m_stb ^ flip;
      h2 = h1;
      h1 = keys_raw;
    end
  endtask

  task automatic cyc();
    logic acc;
    logic [4:0] ae;
    acc = (evt_valid === 1'b1) && (evt_ready === 1'b1);
    ae = {evt_key, evt_press};
    @(posedge clk);
    model_step();
    if (acc && reset) evq.push_back(ae);
    #1;
    if (evt_overrun === 1'b1) ovr_cnt++;
    chk("stable", 32'(keys_stable), 32'(m_stb));
    chk("any_key", 32'(any_key), 32'(m_any));
    chk("active_key", 32'(active_key), 32'(m_act));
    chk("overrun", 32'(evt_overrun), 32'(m_ovr));
    chk("evt_valid", 32'(evt_valid), 32'(m_v));
    if (m_v) chk("evt_kp", 32'({evt_key, evt_press}), 32'({m_k, m_p}));
  endtask

  initial begin
    int n;
    reset = 1'b0;
    keys_raw = 16'hFFFF;
    evt_ready = 1'b0;

    // 1: reset with all keys asserted
    repeat (5) begin
      cyc();
      chk("t1_stable", 32'(keys_stable), 0);
      chk("t1_valid", 32'(evt_valid), 0);
      chk("t1_any", 32'(any_key), 0);
      chk("t1_act", 32'(active_key), 0);
      chk("t1_ovr", 32'(evt_overrun), 0);
    end
    reset = 1'b1;
    keys_raw = '0;
    evt_ready = 1'b1;
    repeat (20) cyc();
    evq.delete();

    // 2: long press and release of key 0
    keys_raw = 16'h0001;
    for (n = 0; n < 40 && keys_stable[0] !== 1'b1; n++) cyc();
    chk("t2_latency", 32'(n <= SS + SC * TD), 1);
    repeat (80 - n) cyc();
    chk("t2_press_n", evq.size(), 1);
    if (evq.size() > 0) chk("t2_press_e", 32'(evq[0]), 32'(5'b00001));
    keys_raw = '0;
    repeat (80) cyc();
    chk("t2_rel_n", evq.size(), 2);
    if (evq.size() > 1) chk("t2_rel_e", 32'(evq[1]), 32'(5'b00000));
    evq.delete();

    // 3: glitch of two ticks on key 5
    ovr_cnt = 0;
    keys_raw = 16'h0020;
    repeat (2 * TD) cyc();
    keys_raw = '0;
    repeat (40) cyc();
    chk("t3_stable", 32'(keys_stable), 0);
    chk("t3_events", evq.size(), 0);
    chk("t3_ovr", ovr_cnt, 0);

    // 4: simultaneous keys 3 and 9 under backpressure
    evt_ready = 1'b0;
    keys_raw = 16'h0208;
    for (n = 0; n < 40 && evt_valid !== 1'b1; n++) cyc();
    chk("t4_valid", 32'(evt_valid), 1);
    chk("t4_key", 32'(evt_key), 3);
    chk("t4_press", 32'(evt_press), 1);
    repeat (6) begin
      cyc();
      chk("t4_hold", 32'({evt_valid, evt_key}), 32'({1'b1, 4'd3}));
    end
    evt_ready = 1'b1;
    cyc();
    chk("t4_acc3", 32'(evq.size() == 1 && evq[0] == 5'b00111), 1);
    chk("t4_next", 32'({evt_valid, evt_key}), 32'({1'b1, 4'd9}));
    cyc();
    chk("t4_empty", 32'(evt_valid), 0);
    chk("t4_acc9", 32'(evq.size() == 2 && evq[1] == 5'b10011), 1);
    evq.delete();

    // 5: key 7 pulses while its press is still pending
    evt_ready = 1'b0;
    ovr_cnt = 0;
    keys_raw = keys_raw | 16'h0004;
    for (n = 0; n < 40 && evt_valid !== 1'b1; n++) cyc();
    chk("t5_key2", 32'({evt_valid, evt_key, evt_press}), 32'({1'b1, 4'd2, 1'b1}));
    keys_raw = keys_raw | 16'h0080;
    for (n = 0; n < 40 && keys_stable[7] !== 1'b1; n++) cyc();
    keys_raw = keys_raw & ~16'h0080;
    for (n = 0; n < 40 && keys_stable[7] !== 1'b0; n++) cyc();
    repeat (2) cyc();
    chk("t5_ovr", ovr_cnt, 1);
    evt_ready = 1'b1;
    repeat (4) cyc();
    chk("t5_n", evq.size(), 2);
    if (evq.size() > 1) begin
      chk("t5_e0", 32'(evq[0]), 32'(5'b00101));
      chk("t5_e1", 32'(evq[1]), 32'(5'b01110));
    end
    evq.delete();

    // 6: reset while an event is held
    evt_ready = 1'b0;
    keys_raw = keys_raw | 16'h1000;
    for (n = 0; n < 40 && evt_valid !== 1'b1; n++) cyc();
    chk("t6_valid", 32'(evt_valid), 1);
    reset = 1'b0;
    cyc();
    chk("t6_out", 32'({keys_stable, any_key, active_key, evt_valid,
                       evt_overrun}), 0);
    reset = 1'b1;
    evt_ready = 1'b1;
    evq.delete();
    repeat (60) cyc();
    chk("t6_n", evq.size(), 4);
    if (evq.size() > 3) begin
      chk("t6_e0", 32'(evq[0]), 32'(5'b00101));
      chk("t6_e1", 32'(evq[1]), 32'(5'b00111));
      chk("t6_e2", 32'(evq[2]), 32'(5'b10011));
      chk("t6_e3", 32'(evq[3]), 32'(5'b11001));
    end

    // random traffic against the model
    repeat (3000) begin
      evt_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        keys_raw[$urandom_range(0, 15)] ^= 1'b1;
      reset = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
